// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchroniser followed by a four-state debounce FSM.
// The block accepts a level change only after the synchronised input has held
// the new level for DB_CYCLES+1 consecutive samples. It emits a one-cycle
// db_clk pulse on each accepted press. No pulse is issued on release.
//
//   state | meaning
//   ZERO  | settled released, q=0, cnt held at 0
//   WAIT1 | s=1 seen while released, counting stable-high samples
//   ONE   | settled pressed, q=1, cnt held at 0
//   WAIT0 | s=0 seen while pressed, counting stable-low samples
module btn_debounce #(
  parameter int DB_CYCLES = 1_000_000,
  parameter int CNT_W     = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic q,
  output logic db_clk
);

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             s1;
  logic             s;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             q_nxt;
  logic             db_nxt;

  // Bring the asynchronous button level into the clk domain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s  <= 1'b0;
    end else begin
      s1 <= raw;
      s  <= s1;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ZERO;
      cnt    <= '0;
      q      <= 1'b0;
      db_clk <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      q      <= q_nxt;
      db_clk <= db_nxt;
    end
  end

  // Next-state and counter update. Any opposing sample restarts the count.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    case (state)
      ZERO: begin
        if (s) state_nxt = WAIT1;
      end
      WAIT1: begin
        if (!s) begin
          state_nxt = ZERO;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ONE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ONE: begin
        if (!s) state_nxt = WAIT0;
      end
      WAIT0: begin
        if (s) begin
          state_nxt = ONE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ZERO;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ZERO;
      end
    endcase
  end

  // Outputs are registered from the next state so q tracks the accepted level
  // and db_clk is high for the first cycle of q=1 only.
  always_comb begin
    q_nxt  = (state_nxt == ONE) || (state_nxt == WAIT0);
    db_nxt = (state == WAIT1) && (state_nxt == ONE);
  end

endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: table-driven, directed and random checks of btn_debounce
// with DB_CYCLES=4 against a run-length reference model.
module tb_btn_debounce;

  localparam int DB = 4;
  localparam int CW = 3;

  typedef struct {
    logic raw;
    logic q;
    logic db;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic raw = 1'b0;
  logic q;
  logic db_clk;

  int checks = 0;
  int failures = 0;

  // reference model: s pipeline plus run length of samples opposing q
  logic m_s1, m_s, m_q, m_db;
  int   m_run;

  vec_t vecs[$];

  btn_debounce #(.DB_CYCLES(DB), .CNT_W(CW)) dut (
    .clk(clk),
    .reset(reset),
    .raw(raw),
    .q(q),
    .db_clk(db_clk)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 1'b0;
    m_s = 1'b0;
    m_q = 1'b0;
    m_db = 1'b0;
    m_run = 0;
  endtask

  task automatic model_edge();
    logic s_used;
    s_used = m_s;
    m_s = m_s1;
    m_s1 = raw;
    m_db = 1'b0;
    if (s_used !== m_q) begin
      m_run++;
      if (m_run == DB + 1) begin
        m_q = ~m_q;
        m_db = m_q;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic step(input logic r);
    raw = r;
    @(posedge clk);
    model_edge();
    #1;
    check("model_q", q, m_q);
    check("model_db", db_clk, m_db);
  endtask

  function automatic void add(input logic r, input logic eq, input logic ed);
    vec_t v;
    v.raw = r;
    v.q = eq;
    v.db = ed;
    vecs.push_back(v);
  endfunction

  function automatic void add_n(input int n, input logic r, input logic eq);
    for (int i = 0; i < n; i++) add(r, eq, 1'b0);
  endfunction

  initial begin
    int pulses;
    int pulse_at;
    int run_len;
    logic lvl;
    logic prev_db;
    logic [7:0] cnt8;

    model_reset();
    #2 reset = 1'b0;
    #1;
    check("reset_q", q, 1'b0);
    check("reset_db", db_clk, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold_q", q, 1'b0);
    check("reset_hold_db", db_clk, 1'b0);
    reset = 1'b1;

    // idle low
    add_n(3, 1'b0, 1'b0);
    // clean press: pulse after E6
    add_n(6, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b1);
    add_n(5, 1'b1, 1'b1);
    // release: q falls after E6, no pulse
    add_n(6, 1'b0, 1'b1);
    add_n(6, 1'b0, 1'b0);
    // glitch in ZERO: three high samples rejected
    add_n(3, 1'b1, 1'b0);
    add_n(7, 1'b0, 1'b0);
    // bounce 1,0,1,0 then settle high: pulse 6 edges after last 0->1 sample
    add(1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0);
    add_n(6, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b1);
    add_n(4, 1'b1, 1'b1);
    // two-cycle low glitch in ONE keeps q high
    add_n(2, 1'b0, 1'b1);
    add_n(8, 1'b1, 1'b1);
    // second release
    add_n(6, 1'b0, 1'b1);
    add_n(6, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].raw);
      check($sformatf("vec%0d_q", i), q, vecs[i].q);
      check($sformatf("vec%0d_db", i), db_clk, vecs[i].db);
    end

    // reset while db_clk is high clears it at once; button held through reset
    for (int i = 0; i < 7; i++) step(1'b1);
    check("pre_rst_pulse_db", db_clk, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("rst_pulse_q", q, 1'b0);
    check("rst_pulse_db", db_clk, 1'b0);
    model_reset();
    #2 reset = 1'b1;
    pulses = 0;
    pulse_at = -1;
    for (int e = 0; e < 12; e++) begin
      step(1'b1);
      if (db_clk === 1'b1) begin
        pulses++;
        if (pulse_at < 0) pulse_at = e;
      end
    end
    check("held_rst_one_pulse", pulses == 1, 1'b1);
    check("held_rst_pulse_edge", pulse_at == 6, 1'b1);

    // reset during WAIT1 with cnt=2 aborts the press
    for (int i = 0; i < 12; i++) step(1'b0);
    for (int i = 0; i < 5; i++) step(1'b1);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_q", q, 1'b0);
    check("rst_mid_db", db_clk, 1'b0);
    model_reset();
    #2 reset = 1'b1;
    pulses = 0;
    pulse_at = -1;
    for (int e = 0; e < 12; e++) begin
      step(1'b1);
      if (db_clk === 1'b1) begin
        pulses++;
        if (pulse_at < 0) pulse_at = e;
      end
    end
    check("rst_mid_one_pulse", pulses == 1, 1'b1);
    check("rst_mid_pulse_edge", pulse_at == 6, 1'b1);

    // ten clean presses feeding a downstream 8-bit counter
    for (int i = 0; i < 20; i++) step(1'b0);
    cnt8 = 8'h00;
    prev_db = 1'b0;
    for (int p = 0; p < 10; p++) begin
      for (int i = 0; i < 40; i++) begin
        step(i < 20);
        if (db_clk === 1'b1) cnt8 = cnt8 + 8'h01;
        if (prev_db === 1'b1) check("pulse_width", db_clk, 1'b0);
        prev_db = db_clk;
      end
    end
    checks++;
    if (cnt8 !== 8'h0A) begin
      failures++;
      $display("FAIL press_count: got %h expected 0a", cnt8);
    end

    // random bouncy stimulus against the model
    lvl = 1'b0;
    for (int n = 0; n < 1500; ) begin
      lvl = ~lvl;
      run_len = $urandom_range(1, 8);
      for (int k = 0; k < run_len; k++) begin
        step(lvl);
        n++;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Debounces one raw mechanical push-button input and produces a clean level plus a single-cycle press pulse. It sits directly upstream of the button-count and display logic: `db_clk` drives a counter enable, and `q` is available as the debounced level. One instance is used per button. The raw input is asynchronous to `clk` and is synchronised inside the block.

## Interface
- `DB_CYCLES`, default 1_000_000: consecutive synchronised-stable cycles required to accept a level change (10 ms at 100 MHz); legal range ≥ 2.
- `CNT_W`, default 20: counter width; must satisfy 2^CNT_W ≥ DB_CYCLES.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `raw`  in  1  raw button level, asynchronous, bouncy; 1 = pressed.
- `q`  out  1  debounced level, registered.
- `db_clk`  out  1  one-cycle pulse, registered, on every accepted 0→1 transition of `q`.

## Operation
- Synchroniser: two flops, `raw` → `s1` → `s`. The FSM uses only `s`.
- FSM states: ZERO, WAIT1, ONE, WAIT0. The counter `cnt` is CNT_W bits.
- ZERO: `q`=0. If `s`=1, go to WAIT1 with `cnt`←0.
- WAIT1: `q`=0.
  - If `s`=0, go to ZERO with `cnt`←0 (glitch rejected, no pulse).
  - Else if `cnt`=DB_CYCLES-1, go to ONE: `q`←1 and `db_clk`←1 for one cycle.
  - Else `cnt`←`cnt`+1.
- ONE: `q`=1. If `s`=0, go to WAIT0 with `cnt`←0.
- WAIT0: `q`=1.
  - If `s`=1, go to ONE with `cnt`←0.
  - Else if `cnt`=DB_CYCLES-1, go to ZERO with `q`←0 (no pulse on release).
  - Else `cnt`←`cnt`+1.
- `cnt` never exceeds DB_CYCLES-1 and never wraps. In ZERO and ONE, `cnt` holds at 0.
- `db_clk` is high only on the single cycle after the WAIT1→ONE transition edge, i.e. coincident with the first cycle of `q`=1. It is never high on consecutive cycles.
- Any `s` sample opposite to the pending level restarts the full count. Acceptance requires exactly DB_CYCLES+1 consecutive matching `s` samples: one in ZERO or ONE, then DB_CYCLES in the WAIT state.

## Timing
- Reset (`reset`=0, asynchronous): `s1`=`s`=0, state=ZERO, `cnt`=0, `q`=0, `db_clk`=0. Outputs go low immediately, without waiting for a clock edge.
- Press latency: let raw be first sampled high at edge E0 and held.
  - `s`=1 after E1.
  - The FSM enters WAIT1 at E2.
  - `q`=1 and `db_clk`=1 after edge E(DB_CYCLES+2).
  - `db_clk` returns to 0 after E(DB_CYCLES+3).
- Release latency is identical: `q`=0 after E(DB_CYCLES+2) relative to the first low sample. `db_clk` stays 0 throughout.
- Reset asserted during WAIT1 aborts the press: no pulse is issued and `q` stays 0.
- Reset asserted while `db_clk`=1 clears the pulse immediately.
- Button held through reset release: this is treated as a fresh press. Full press latency applies and exactly one `db_clk` is issued.
- Reset deassertion is synchronous-safe: it is released by a synchronised reset at the top level, not handled inside this block.

## Test plan
- Clean press, DB_CYCLES=4:
  - Stimulus: `raw` 0→1 before edge E0 and held.
  - Required: `q`=0 through E5; `q`=1 and `db_clk`=1 after E6; `db_clk`=0 after E7; `q` stays 1.
- Bounce on press, DB_CYCLES=4: raw toggles 1,0,1,0 on consecutive cycles, then settles at 1.
  - Required: exactly one `db_clk` pulse, occurring 6 edges after the last 0→1 sample.
  - Required: `q` never toggles during the bounce.
- Glitch rejection, DB_CYCLES=4: in ZERO, `raw`=1 for 3 cycles, then 0.
  - Required: `q`=0 and `db_clk`=0 throughout.
- Release, DB_CYCLES=4:
  - From ONE, `raw`→0 held: `q`=0 after 6 edges, with no `db_clk`.
  - A 2-cycle low glitch in ONE leaves `q`=1.
- Reset mid-count, DB_CYCLES=4: assert `reset`=0 asynchronously during WAIT1 (`cnt`=2), then release with `raw` still 1.
  - Required: outputs 0 immediately.
  - Required: one `db_clk` pulse, occurring 6 edges after the first post-reset raw sample.
- Repeated presses, DB_CYCLES=4: apply 10 clean press/release cycles (each level held for 20 cycles).
  - Required: exactly 10 `db_clk` pulses, each 1 cycle wide.
  - Required: a downstream 8-bit counter reads 8'h0A.
